// File: rtl/tdm_pkg.sv
// Shared types and constants for the TDM 1:4 demultiplexer and its slot counter.
package tdm_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;
  localparam int ERR_CNT_W = 8;
  localparam int MISS_W    = 4;

  typedef logic [SLOT_W-1:0] slot_t;

  // Slot index after a beat; the 2-bit width makes slot 3 wrap to 0.
  function automatic slot_t next_slot(input slot_t cur);
    return cur + slot_t'(1);
  endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot counter (advance, load-to-1, clear) and consecutive missing-sync counter
// (increment with saturation, clear) for the TDM demultiplexer.
module tdm_slot_ctr
  import tdm_pkg::*;
#(
  parameter int MISS_MAX = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  slot_adv,
  input  logic  slot_load1,
  input  logic  slot_clr,
  input  logic  miss_inc,
  input  logic  miss_clr,
  output slot_t slot,
  output logic  miss_limit
);

  logic [MISS_W-1:0] miss_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (slot_clr) begin
      slot <= '0;
    end else if (slot_load1) begin
      slot <= slot_t'(1);
    end else if (slot_adv) begin
      slot <= next_slot(slot);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_q <= '0;
    end else if (miss_clr) begin
      miss_q <= '0;
    end else if (miss_inc && (miss_q != '1)) begin
      miss_q <= miss_q + MISS_W'(1);
    end
  end

  // High when one more missing sync would reach the drop-lock threshold.
  assign miss_limit = ((int'(miss_q) + 1) >= MISS_MAX);

endmodule

// File: rtl/tdm_demux1to4.sv
// TDM 1:4 demultiplexer: rebuilds four channels from a slot-ordered beat stream
// with frame-sync lock tracking. Optional error counter under TDM_DEMUX_ERR_CNT_EN.
module tdm_demux1to4
  import tdm_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int MISS_MAX = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic             s1,
  output logic             s0,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3,
  output logic             frame_valid,
  output logic             locked,
  output logic             sync_err
`ifdef TDM_DEMUX_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  // Handshake: din_valid qualifies din and frame_sync together; there is no
  // backpressure, so every valid beat is consumed in the cycle it appears.

  state_e           state_q, state_d;
  slot_t            slot;
  logic             miss_limit;
  logic             slot_adv, slot_load1, slot_clr;
  logic             miss_inc, miss_clr;
  logic             cap_slot0, cap_shadow, commit, err_pulse, drop_lock;
  logic [WIDTH-1:0] shadow0, shadow1, shadow2;

  tdm_slot_ctr #(
    .MISS_MAX(MISS_MAX)
  ) u_slot_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .slot_adv  (slot_adv),
    .slot_load1(slot_load1),
    .slot_clr  (slot_clr),
    .miss_inc  (miss_inc),
    .miss_clr  (miss_clr),
    .slot      (slot),
    .miss_limit(miss_limit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    slot_adv   = 1'b0;
    slot_load1 = 1'b0;
    slot_clr   = 1'b0;
    miss_inc   = 1'b0;
    miss_clr   = 1'b0;
    cap_slot0  = 1'b0;
    cap_shadow = 1'b0;
    commit     = 1'b0;
    err_pulse  = 1'b0;
    drop_lock  = 1'b0;
    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (frame_sync) begin
            state_d    = LOCKED;
            cap_slot0  = 1'b1;
            slot_load1 = 1'b1;
            miss_clr   = 1'b1;
          end
        end
        LOCKED: begin
          if (slot == '0) begin
            if (frame_sync) begin
              cap_slot0  = 1'b1;
              slot_load1 = 1'b1;
              miss_clr   = 1'b1;
            end else if (miss_limit) begin
              state_d   = HUNT;
              slot_clr  = 1'b1;
              miss_clr  = 1'b1;
              drop_lock = 1'b1;
            end else begin
              cap_slot0  = 1'b1;
              slot_load1 = 1'b1;
              miss_inc   = 1'b1;
            end
          end else if (frame_sync) begin
            // Misaligned sync: abandon the partial frame and restart at slot 0.
            err_pulse  = 1'b1;
            cap_slot0  = 1'b1;
            slot_load1 = 1'b1;
            miss_clr   = 1'b1;
          end else if (slot == slot_t'(NUM_SLOTS - 1)) begin
            commit   = 1'b1;
            slot_adv = 1'b1;
          end else begin
            cap_shadow = 1'b1;
            slot_adv   = 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow0 <= '0;
      shadow1 <= '0;
      shadow2 <= '0;
    end else begin
      if (cap_slot0) begin
        shadow0 <= din;
      end
      if (cap_shadow) begin
        case (slot)
          slot_t'(1): shadow1 <= din;
          slot_t'(2): shadow2 <= din;
          default:    ;
        endcase
      end
    end
  end

  // All four channels update in the same edge so q never mixes two frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0          <= '0;
      q1          <= '0;
      q2          <= '0;
      q3          <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= commit;
      sync_err    <= err_pulse;
      if (commit) begin
        q0 <= shadow0;
        q1 <= shadow1;
        q2 <= shadow2;
        q3 <= din;
      end
    end
  end

`ifdef TDM_DEMUX_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if ((err_pulse || drop_lock) && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end
`endif

  assign locked = (state_q == LOCKED);
  assign s1     = slot[1];
  assign s0     = slot[0];

endmodule

// File: tb/tb_tdm_demux1to4.sv
// Directed bench for tdm_demux1to4 (WIDTH=1, MISS_MAX=2); the error counter
// is exercised when TDM_DEMUX_ERR_CNT_EN is defined.
module tb_tdm_demux1to4;

  logic       clk;
  logic       rst_n;
  logic [0:0] din;
  logic       din_valid;
  logic       frame_sync;
  logic       s1, s0;
  logic [0:0] q0, q1, q2, q3;
  logic       frame_valid;
  logic       locked;
  logic       sync_err;
`ifdef TDM_DEMUX_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  tdm_demux1to4 #(
    .WIDTH   (1),
    .MISS_MAX(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .s1         (s1),
    .s0         (s0),
    .q0         (q0),
    .q1         (q1),
    .q2         (q2),
    .q3         (q3),
    .frame_valid(frame_valid),
    .locked     (locked),
    .sync_err   (sync_err)
`ifdef TDM_DEMUX_ERR_CNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic send(input logic d, input logic s);
    din        = d;
    din_valid  = 1'b1;
    frame_sync = s;
    @(posedge clk);
    #1;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_q(input string tag, input logic [3:0] exp);
    check(tag, {28'd0, q0, q1, q2, q3}, {28'd0, exp});
  endtask

  task automatic check_ctl(input string tag, input logic [1:0] slot_e, input logic lk,
                           input logic fv, input logic se);
    check({tag, "_slot"}, {30'd0, s1, s0}, {30'd0, slot_e});
    check({tag, "_locked"}, {31'd0, locked}, {31'd0, lk});
    check({tag, "_fv"}, {31'd0, frame_valid}, {31'd0, fv});
    check({tag, "_serr"}, {31'd0, sync_err}, {31'd0, se});
  endtask

  initial begin
    rst_n      = 1'b1;
    din        = '0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    #2 rst_n = 1'b0;
    idle(3);
    check_ctl("reset", 2'd0, 1'b0, 1'b0, 1'b0);
    check_q("reset_q", 4'b0000);
`ifdef TDM_DEMUX_ERR_CNT_EN
    check("reset_errcnt", {24'd0, err_cnt}, 32'd0);
`endif
    rst_n = 1'b1;
    idle(1);

    // HUNT ignores unsynced beats and sync without valid
    send(1'b1, 1'b0);
    check_ctl("hunt_nosync", 2'd0, 1'b0, 1'b0, 1'b0);
    frame_sync = 1'b1;
    idle(1);
    frame_sync = 1'b0;
    check_ctl("hunt_sync_novalid", 2'd0, 1'b0, 1'b0, 1'b0);

    // frame 1: 0,1,0,1
    send(1'b0, 1'b1);
    check_ctl("f1_b0", 2'd1, 1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b0);
    check_ctl("f1_b1", 2'd2, 1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b0);
    check_ctl("f1_b2", 2'd3, 1'b1, 1'b0, 1'b0);
    check_q("f1_q_before", 4'b0000);
    send(1'b1, 1'b0);
    check_ctl("f1_b3", 2'd0, 1'b1, 1'b1, 1'b0);
    check_q("f1_q", 4'b0101);
    idle(1);
    check_ctl("f1_after", 2'd0, 1'b1, 1'b0, 1'b0);

    // frame 2: 1,0,1,0 with a 3-cycle gap after slot 1
    send(1'b1, 1'b1);
    send(1'b0, 1'b0);
    idle(3);
    check_ctl("f2_gap", 2'd2, 1'b1, 1'b0, 1'b0);
    check_q("f2_gap_q", 4'b0101);
    send(1'b1, 1'b0);
    check_q("f2_b2_q", 4'b0101);
    send(1'b0, 1'b0);
    check_ctl("f2_b3", 2'd0, 1'b1, 1'b1, 1'b0);
    check_q("f2_q", 4'b1010);

    // misaligned sync on slot 2; that beat becomes q0 of the next frame
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    send(1'b0, 1'b1);
    check_ctl("mis_sync", 2'd1, 1'b1, 1'b0, 1'b1);
    check_q("mis_q_held", 4'b1010);
    send(1'b0, 1'b0);
    check_ctl("mis_b1", 2'd2, 1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    check_ctl("mis_commit", 2'd0, 1'b1, 1'b1, 1'b0);
    check_q("mis_q", 4'b0011);
`ifdef TDM_DEMUX_ERR_CNT_EN
    check("mis_errcnt", {24'd0, err_cnt}, 32'd1);
`endif

    // two frames without sync: first completes, second loses lock
    send(1'b1, 1'b0);
    check_ctl("miss1_b0", 2'd1, 1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    check_ctl("miss1_commit", 2'd0, 1'b1, 1'b1, 1'b0);
    check_q("miss1_q", 4'b1101);
    send(1'b0, 1'b0);
    check_ctl("miss2_drop", 2'd0, 1'b0, 1'b0, 1'b0);
    check_q("miss2_q", 4'b1101);
`ifdef TDM_DEMUX_ERR_CNT_EN
    check("miss_errcnt", {24'd0, err_cnt}, 32'd2);
`endif
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    check_ctl("miss_hunt", 2'd0, 1'b0, 1'b0, 1'b0);
    send(1'b1, 1'b1);
    check_ctl("relock", 2'd1, 1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b0);
    check_ctl("pre_rst", 2'd2, 1'b1, 1'b0, 1'b0);

    // asynchronous reset in the middle of slot 2
    rst_n = 1'b0;
    #1;
    check_ctl("async_rst", 2'd0, 1'b0, 1'b0, 1'b0);
    check_q("async_rst_q", 4'b0000);
`ifdef TDM_DEMUX_ERR_CNT_EN
    check("async_rst_errcnt", {24'd0, err_cnt}, 32'd0);
`endif
    idle(1);
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 4; i++) send(1'b1, 1'b0);
    check_ctl("post_rst_nosync", 2'd0, 1'b0, 1'b0, 1'b0);
    check_q("post_rst_q", 4'b0000);
    send(1'b1, 1'b1);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    check_ctl("post_rst_frame", 2'd0, 1'b1, 1'b1, 1'b0);
    check_q("post_rst_frame_q", 4'b1011);

`ifdef TDM_DEMUX_ERR_CNT_EN
    // repeated misaligned syncs saturate the counter
    send(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) send(1'($urandom_range(0, 1)), 1'b1);
    check("errcnt_10", {24'd0, err_cnt}, 32'd10);
    for (int i = 0; i < 290; i++) send(1'($urandom_range(0, 1)), 1'b1);
    check("errcnt_sat", {24'd0, err_cnt}, 32'd255);
    check_ctl("errcnt_lock", 2'd1, 1'b1, 1'b0, 1'b1);
    send(1'b0, 1'b1);
    check("errcnt_hold", {24'd0, err_cnt}, 32'd255);
`endif

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
